pipelined_accumulator_machine: RTL and testbench

Parametrised successor to the adding-machine datapath. It walks a programmable window of a word-addressed memory and reduces the words into one accumulator through a configurable number of pipeline register stages. The reduction is add, subtract, signed max or XOR. Runs are started and finished with a start/busy/done handshake, and a sticky signed-overflow flag is kept. The block sits between a combinational-read memory (ROM or register file) and the consumer of the reduced value.

---
 rtl/pipelined_accumulator_machine_if.sv | 30 +++
 rtl/pipelined_accumulator_machine.sv | 161 ++++++++++++++++
 tb/tb_pipelined_accumulator_machine.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_accumulator_machine_if.sv
// Bus bundle for pipelined_accumulator_machine: run control, memory read port and results.
//   start/base_addr/count/mode : run request, sampled by the accumulator in IDLE
//   mem_addr/mem_data          : combinational-read memory port
//   busy/done/out/overflow     : run status and reduced result
// Modport slave is the accumulator side; master is the controller/memory side.
interface pipelined_accumulator_machine_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 30
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] count;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_data;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  out;
   logic              overflow;

   modport master (
      output start, base_addr, count, mode, mem_data,
      input  mem_addr, busy, done, out, overflow
   );

   modport slave (
      input  start, base_addr, count, mode, mem_data,
      output mem_addr, busy, done, out, overflow
   );
endinterface

// File: rtl/pipelined_accumulator_machine.sv
// Walks count words starting at base_addr in a combinational-read memory and reduces them into
// one accumulator (add, subtract, signed max, XOR) through PIPE register stages.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : slave side of pipelined_accumulator_machine_if (start/base_addr/count/mode in,
//             mem_addr out, mem_data in, busy/done/out/overflow out)
module pipelined_accumulator_machine #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 30,
   parameter int unsigned PIPE   = 1
) (
   input logic                            i_clk,
   input logic                            i_rst_n,
   pipelined_accumulator_machine_if.slave io_bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   localparam logic [1:0]       ModeAdd  = 2'b00;
   localparam logic [1:0]       ModeSub  = 2'b01;
   localparam logic [1:0]       ModeMax  = 2'b10;
   localparam logic [1:0]       ModeXor  = 2'b11;
   localparam logic [WIDTH-1:0] MinVal   = {1'b1, {(WIDTH-1){1'b0}}};
   // Only the final stage still holds a word: the next edge performs the last update.
   localparam logic [PIPE-1:0]  LastOnly = PIPE'(1) << (PIPE-1);

   state_e            r_state, w_state_next;
   logic [ADDR_W-1:0] r_addr, w_addr_next;
   logic [ADDR_W-1:0] r_remain, w_remain_next;
   logic [1:0]        r_mode;
   logic [WIDTH-1:0]  r_acc, w_acc_next;
   logic              r_ovf, w_ovf_next;
   logic              r_done, w_done_next;
   logic              w_accept, w_capture;

   logic [WIDTH-1:0]  r_pipe_data [PIPE];
   logic [PIPE-1:0]   r_pipe_vld;

   logic [WIDTH-1:0]  w_word, w_sum, w_diff;
   logic              w_add_ovf, w_sub_ovf;

   // ---------------------------------------------------------------- control FSM
   always_comb begin
      w_state_next  = r_state;
      w_addr_next   = r_addr;
      w_remain_next = r_remain;
      w_done_next   = 1'b0;
      w_accept      = 1'b0;
      w_capture     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (io_bus.start) begin
               w_accept = 1'b1;
               if (io_bus.count == '0) begin
                  w_done_next = 1'b1;
               end else begin
                  w_state_next  = StRun;
                  w_addr_next   = io_bus.base_addr;
                  w_remain_next = io_bus.count;
               end
            end
         end
         StRun: begin
            w_capture     = 1'b1;
            w_remain_next = r_remain - ADDR_W'(1);
            // Address stays on the last issued word once the final capture is taken.
            if (r_remain == ADDR_W'(1)) begin
               w_state_next = StDrain;
            end else begin
               w_addr_next = r_addr + ADDR_W'(1);
            end
         end
         StDrain: begin
            if ((r_pipe_vld == LastOnly) || (r_pipe_vld == '0)) begin
               w_state_next = StIdle;
               w_done_next  = 1'b1;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // ---------------------------------------------------------------- reduction
   always_comb begin
      w_word     = r_pipe_data[PIPE-1];
      w_sum      = r_acc + w_word;
      w_diff     = r_acc - w_word;
      w_add_ovf  = (r_acc[WIDTH-1] == w_word[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
      w_sub_ovf  = (r_acc[WIDTH-1] != w_word[WIDTH-1]) && (w_diff[WIDTH-1] != r_acc[WIDTH-1]);
      w_acc_next = r_acc;
      w_ovf_next = r_ovf;
      if (w_accept) begin
         w_acc_next = (io_bus.mode == ModeMax) ? MinVal : '0;
         w_ovf_next = 1'b0;
      end else if (r_pipe_vld[PIPE-1]) begin
         unique case (r_mode)
            ModeAdd: begin
               w_acc_next = w_sum;
               w_ovf_next = r_ovf | w_add_ovf;
            end
            ModeSub: begin
               w_acc_next = w_diff;
               w_ovf_next = r_ovf | w_sub_ovf;
            end
            ModeMax: w_acc_next = ($signed(w_word) > $signed(r_acc)) ? w_word : r_acc;
            ModeXor: w_acc_next = r_acc ^ w_word;
            default: w_acc_next = r_acc;
         endcase
      end
   end

   // ---------------------------------------------------------------- state
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_addr   <= '0;
         r_remain <= '0;
         r_mode   <= ModeAdd;
         r_acc    <= '0;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_addr   <= w_addr_next;
         r_remain <= w_remain_next;
         r_acc    <= w_acc_next;
         r_ovf    <= w_ovf_next;
         r_done   <= w_done_next;
         if (w_accept) begin
            r_mode <= io_bus.mode;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < PIPE; i++) begin
            r_pipe_data[i] <= '0;
         end
      end else begin
         r_pipe_vld[0] <= w_capture;
         if (w_capture) begin
            r_pipe_data[0] <= io_bus.mem_data;
         end
         for (int i = 1; i < PIPE; i++) begin
            r_pipe_vld[i]  <= r_pipe_vld[i-1];
            r_pipe_data[i] <= r_pipe_data[i-1];
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign io_bus.mem_addr = r_addr;
   assign io_bus.busy     = (r_state != StIdle);
   assign io_bus.done     = r_done;
   assign io_bus.out      = r_acc;
   assign io_bus.overflow = r_ovf;

endmodule

// File: tb/tb_pipelined_accumulator_machine.sv
// Bench for pipelined_accumulator_machine: two instances (PIPE=1 and PIPE=3, ADDR_W=4) share
// one stimulus stream and one memory image. Each run pushes its expected result and latency
// into a per-instance queue; a monitor pops and compares whenever an instance raises done.
module tb_pipelined_accumulator_machine;

   localparam logic [1:0] MAdd = 2'b00;
   localparam logic [1:0] MSub = 2'b01;
   localparam logic [1:0] MMax = 2'b10;
   localparam logic [1:0] MXor = 2'b11;

   typedef struct {
      logic [31:0] out;
      logic        ovf;
      int unsigned t0;
      int unsigned lat;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  base;
   logic [3:0]  cnt;
   logic [1:0]  mode;
   logic [31:0] mem [16];
   int unsigned cyc;
   int          n_total;
   int          n_bad;
   exp_t        q1[$];
   exp_t        q3[$];

   pipelined_accumulator_machine_if #(.WIDTH(32), .ADDR_W(4)) bus1 ();
   pipelined_accumulator_machine_if #(.WIDTH(32), .ADDR_W(4)) bus3 ();

   assign bus1.start     = start;
   assign bus1.base_addr = base;
   assign bus1.count     = cnt;
   assign bus1.mode      = mode;
   assign bus1.mem_data  = mem[bus1.mem_addr];
   assign bus3.start     = start;
   assign bus3.base_addr = base;
   assign bus3.count     = cnt;
   assign bus3.mode      = mode;
   assign bus3.mem_data  = mem[bus3.mem_addr];

   pipelined_accumulator_machine #(.WIDTH(32), .ADDR_W(4), .PIPE(1)) u_dut1 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus1)
   );

   pipelined_accumulator_machine #(.WIDTH(32), .ADDR_W(4), .PIPE(3)) u_dut3 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic handle(input int p, input logic [31:0] o, input logic ov, input logic bz);
      exp_t e;
      if ((p == 1) ? (q1.size() == 0) : (q3.size() == 0)) begin
         n_total++;
         n_bad++;
         $display("FAIL p%0d unexpected_done: got done=1 want done=0", p);
      end else begin
         if (p == 1) e = q1.pop_front();
         else        e = q3.pop_front();
         check($sformatf("%s p%0d out", e.name, p), o, e.out);
         check($sformatf("%s p%0d overflow", e.name, p), {31'd0, ov}, {31'd0, e.ovf});
         check($sformatf("%s p%0d latency", e.name, p), cyc - e.t0, e.lat);
         check($sformatf("%s p%0d busy_at_done", e.name, p), {31'd0, bz}, 32'd0);
      end
   endtask

   // Monitor: outputs sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus1.done) handle(1, bus1.out, bus1.overflow, bus1.busy);
         if (bus3.done) handle(3, bus3.out, bus3.overflow, bus3.busy);
      end
   end

   // Issue one start; returns on the falling edge right after the accepting edge E0.
   task automatic run(input string name, input logic [3:0] b, input logic [3:0] c,
                      input logic [1:0] m, input logic [31:0] eo, input logic eov);
      exp_t e;
      @(negedge clk);
      base  = b;
      cnt   = c;
      mode  = m;
      start = 1'b1;
      e.out  = eo;
      e.ovf  = eov;
      e.t0   = cyc;
      e.name = name;
      e.lat  = (c == 0) ? 1 : c + 1 + 1;
      q1.push_back(e);
      e.lat  = (c == 0) ? 1 : c + 3 + 1;
      q3.push_back(e);
      @(negedge clk);
      start = 1'b0;
      if (c == 0) begin
         check({name, " p1 busy_count0"}, {31'd0, bus1.busy}, 32'd0);
         check({name, " p3 busy_count0"}, {31'd0, bus3.busy}, 32'd0);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && (q1.size() != 0 || q3.size() != 0); i++) @(negedge clk);
      if (q1.size() != 0 || q3.size() != 0) begin
         n_total++;
         n_bad++;
         $display("FAIL done_timeout: got pending=%0d want pending=0", q1.size() + q3.size());
         q1.delete();
         q3.delete();
      end
   endtask

   task automatic check_idle_state(input string name);
      check({name, " p1 out"},      bus1.out, 32'd0);
      check({name, " p1 busy"},     {31'd0, bus1.busy}, 32'd0);
      check({name, " p1 done"},     {31'd0, bus1.done}, 32'd0);
      check({name, " p1 mem_addr"}, {28'd0, bus1.mem_addr}, 32'd0);
      check({name, " p1 overflow"}, {31'd0, bus1.overflow}, 32'd0);
      check({name, " p3 out"},      bus3.out, 32'd0);
      check({name, " p3 busy"},     {31'd0, bus3.busy}, 32'd0);
      check({name, " p3 mem_addr"}, {28'd0, bus3.mem_addr}, 32'd0);
   endtask

   initial begin
      logic [3:0] ea;
      n_total = 0;
      n_bad   = 0;
      cyc     = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      base    = '0;
      cnt     = '0;
      mode    = MAdd;
      for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
      repeat (3) @(negedge clk);
      check_idle_state("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_state("after_release");

      // mem[a] = a+1
      run("add4", 4'd0, 4'd4, MAdd, 32'd10, 1'b0);
      wait_done();
      run("sub4", 4'd0, 4'd4, MSub, 32'hFFFF_FFF6, 1'b0);
      wait_done();

      mem[0] = 32'd5;
      mem[1] = 32'hFFFF_FFFD;
      mem[2] = 32'h7FFF_FFFF;
      mem[3] = 32'd2;
      run("max4", 4'd0, 4'd4, MMax, 32'h7FFF_FFFF, 1'b0);
      wait_done();
      run("max_count0", 4'd0, 4'd0, MMax, 32'h8000_0000, 1'b0);
      wait_done();

      mem[0] = 32'h7FFF_FFFF;
      mem[1] = 32'd1;
      mem[2] = 32'hFFFF_FFFF;
      run("ovf", 4'd0, 4'd3, MAdd, 32'h7FFF_FFFF, 1'b1);
      wait_done();
      run("count0_clear", 4'd0, 4'd0, MAdd, 32'd0, 1'b0);
      wait_done();

      // Wrap: mem[a] = a, addresses 14, 15, 0, 1 XOR to zero.
      for (int i = 0; i < 16; i++) mem[i] = 32'(i);
      run("wrap_xor", 4'd14, 4'd4, MXor, 32'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         ea = 4'(14 + k);
         check($sformatf("wrap p1 mem_addr[%0d]", k), {28'd0, bus1.mem_addr}, {28'd0, ea});
         check($sformatf("wrap p3 mem_addr[%0d]", k), {28'd0, bus3.mem_addr}, {28'd0, ea});
         if (k < 3) @(negedge clk);
      end
      wait_done();

      // Start pulsed mid-run must not disturb the run in flight.
      for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
      run("ignore_start", 4'd0, 4'd4, MAdd, 32'd10, 1'b0);
      @(negedge clk);
      base  = 4'd5;
      cnt   = 4'd1;
      mode  = MSub;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Reset asserted just after E2 of a count=8 run: everything clears, no done follows.
      run("reset_run", 4'd0, 4'd8, MAdd, 32'd36, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_idle_state("mid_reset");
      q1.delete();
      q3.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      run("after_reset", 4'd0, 4'd4, MAdd, 32'd10, 1'b0);
      wait_done();

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
